adc_sampler: RTL and testbench
==============================

# adc_sampler

Single-shot SPI conversion controller for the DE0-Nano's on-board ADC128S022, sitting upstream of the MCU register file. The MCU writes a channel number through the `r_load_data` / `r_load` register-load path. The block then runs two 16-bit SPI frames on `ADC_CS_N` / `ADC_SCLK` / `ADC_SADDR` / `ADC_SDAT`: the first addresses the channel, the second reads it. It presents a tagged 12-bit result on a read-only source register (`r[SR_ADC]`-style) and raises `busy` for MCU polling.

## Interface
- `CLK_DIV`, default 25: `sysclk` cycles per SCLK half-period. Legal range 8..31, which gives SCLK 3.125 MHz..0.806 MHz at 50 MHz. Default gives 1.0 MHz.
- `sysclk`, in, 1: sole clock, 50 MHz.
- `sysreset`, in, 1: reset, synchronous and active-high.
- `cmd_data`, in, 16: MCU `r_load_data`; bits [2:0] select the channel, bits [15:3] are ignored.
- `cmd_load`, in, 1: MCU `r_load` strobe for this register; starts a conversion.
- `result`, out, 16: {valid, ch[2:0], data[11:0]}.
- `busy`, out, 1: conversion in progress.
- `done`, out, 1: one-cycle pulse when `result` updates.
- `ADC_CS_N`, out, 1: ADC chip select, active low.
- `ADC_SCLK`, out, 1: ADC serial clock; idles high.
- `ADC_SADDR`, out, 1: ADC DIN, the address bits.
- `ADC_SDAT`, in, 1: ADC DOUT; treated as synchronous to `sysclk` (SCLK is derived from it).

## Operation
- **States:** IDLE, SETUP, LOW, HIGH, GAP, FIN. A 5-bit half-period counter `hc` counts 0..CLK_DIV-1. A 4-bit bit index `k` counts 0..15. A frame flag `f` is 0 for the address frame and 1 for the read frame.
- **IDLE:**
  - Outputs: `ADC_CS_N`=1, `ADC_SCLK`=1, `ADC_SADDR`=0, `busy`=0.
  - On `cmd_load`: latch `ch`=`cmd_data[2:0]`, clear `result[15]`, set `f`=0, go to SETUP.
- **SETUP:**
  - Outputs: `ADC_CS_N`=0, `ADC_SCLK`=1.
  - Lasts CLK_DIV cycles (CS-to-SCLK setup), then go to LOW with `k`=0.
- **LOW:**
  - `ADC_SCLK`=0. On entry, drive `ADC_SADDR` = bit (15-k) of {2'b00, ch, 11'b0}, i.e. ch[2] at k=2, ch[1] at k=3, ch[0] at k=4, and 0 otherwise.
  - In the last cycle (`hc`=CLK_DIV-1), sample `ADC_SDAT` into a 16-bit shift register (MSB first). Then go to HIGH.
- **HIGH:**
  - `ADC_SCLK`=1; lasts CLK_DIV cycles.
  - Then: if `k`<15, increment `k` and go to LOW.
  - If `k`=15 and `f`=0, go to GAP.
  - If `k`=15 and `f`=1, go to FIN.
- **GAP:**
  - Outputs: `ADC_CS_N`=1, `ADC_SCLK`=1.
  - Lasts 2×CLK_DIV cycles, then set `f`=1 and go to SETUP.
  - Data shifted in during frame 0 (previous channel's conversion) is discarded.
- **FIN:**
  - Lasts one cycle: `ADC_CS_N`=1, `result` <= {1'b1, ch, shift[11:0]}, `done`=1.
  - Go to IDLE. `busy` is low in the FIN cycle.
- **`result`:** holds its value until the next accepted `cmd_load`. Bits [15:12] are updated only in FIN (clearing of bit 15 on accept excepted). The leading 4 SDAT bits (shift[15:12]) are ignored.
- **`cmd_load` while busy:** ignored. No re-latch, no restart.
- **`cmd_load` in the FIN cycle:** ignored. It is accepted only in IDLE.
- **Reset:** `sysreset` forces IDLE from any state, including mid-frame.
  - Next-edge values: `ADC_CS_N`=1, `ADC_SCLK`=1, `ADC_SADDR`=0, `busy`=0, `done`=0, `result`=16'h0000.
  - The aborted conversion produces no `done`.

## Timing
- `cmd_load` sampled at edge E0. At E0+1, `busy`=1 and `ADC_CS_N`=0.
- Frame length: 33×CLK_DIV cycles (setup plus 32 half-periods).
- GAP length: 2×CLK_DIV cycles.
- `busy` high for exactly 68×CLK_DIV cycles (1700 at default). FIN follows at the next edge, with `done` and the new `result`. At the edge after FIN, `done`=0.
- `cmd_load` to `done`: 68×CLK_DIV+1 cycles.
- SCLK:
  - Exactly 16 rising edges per frame, 32 per conversion.
  - Period 2×CLK_DIV, 50% duty.
  - `ADC_SADDR` changes only on SCLK falling edges.
  - `ADC_SDAT` is sampled one `sysclk` before each SCLK rising edge, i.e. CLK_DIV cycles after the ADC updates DOUT on the falling edge.
- `ADC_CS_N` and `ADC_SCLK` are registered outputs, so no glitches.

## Test plan
- **Reset values:** hold `sysreset` 3 cycles, release → `ADC_CS_N`=1, `ADC_SCLK`=1, `ADC_SADDR`=0, `busy`=0, `done`=0, `result`=16'h0000.
- **Channel 5 read:** ADC behavioural model returns 12'hABC for ch5; `cmd_data`=16'h0005, `cmd_load` 1 cycle →
  - `result`=16'hDABC and `done` exactly 1701 cycles after load.
  - 32 SCLK rises, each period 50 cycles.
  - SADDR pattern 1,0,1 at k=2..4 in both frames.
- **Busy ignore:** start ch2 (model 12'h123); pulse `cmd_load` with ch7 at cycle 400 → `result`=16'hA123, only one `done`, no restart.
- **Reset mid-frame:** assert `sysreset` in frame 1 at k=7 → next edge `ADC_CS_N`=1, `busy`=0, `result`=0, no `done`. A new ch0 read afterward completes normally.
- **Back-to-back:** issue ch1 `cmd_load` in the cycle after FIN → accepted. CS_N high ≥1 cycle between conversions. Second `result` carries ch1 (16'h9xxx).
- **CLK_DIV=8:** ch3 conversion completes in 545 cycles with SCLK period 16. Sampled data equals model 12'hFFF → `result`=16'hBFFF.

Source files
------------

// File: rtl/adc_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adc_sampler                                                                |
// | Single-shot two-frame SPI conversion controller for an ADC128S022.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module adc_sampler #(
    parameter int CLK_DIV = 25
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic [15:0] cmd_data,
    input  logic        cmd_load,
    output logic [15:0] result,
    output logic        busy,
    output logic        done,
    output logic        ADC_CS_N,
    output logic        ADC_SCLK,
    output logic        ADC_SADDR,
    input  logic        ADC_SDAT
);

    localparam logic [4:0] c_HC_LAST = 5'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_GAP   = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  hc_q, hc_d;
    logic [3:0]  k_q, k_d;
    logic        f_q, f_d;
    logic [2:0]  ch_q, ch_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        saddr_q, saddr_d;

    logic        hc_last;
    logic [15:0] addr_word;
    logic        unused_bits;

    assign hc_last     = (hc_q == c_HC_LAST);
    assign addr_word   = {2'b00, ch_q, 11'b0};
    assign unused_bits = ^{cmd_data[15:3], shift_q[15]};

    always_comb begin
        state_d  = state_q;
        hc_d     = hc_q;
        k_d      = k_q;
        f_d      = f_q;
        ch_d     = ch_q;
        shift_d  = shift_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                hc_d = 5'd0;
                if (cmd_load) begin
                    ch_d         = cmd_data[2:0];
                    result_d[15] = 1'b0;
                    f_d          = 1'b0;
                    state_d      = S_SETUP;
                end
            end
            S_SETUP: begin
                if (hc_last) begin
                    hc_d    = 5'd0;
                    k_d     = 4'd0;
                    state_d = S_LOW;
                end else begin
                    hc_d = hc_q + 5'd1;
                end
            end
            S_LOW: begin
                if (hc_last) begin
                    shift_d = {shift_q[14:0], ADC_SDAT};
                    hc_d    = 5'd0;
                    state_d = S_HIGH;
                end else begin
                    hc_d = hc_q + 5'd1;
                end
            end
            S_HIGH: begin
                if (hc_last) begin
                    hc_d = 5'd0;
                    if (k_q != 4'd15) begin
                        k_d     = k_q + 4'd1;
                        state_d = S_LOW;
                    end else if (!f_q) begin
                        k_d     = 4'd0;
                        state_d = S_GAP;
                    end else begin
                        result_d = {1'b1, ch_q, shift_q[11:0]};
                        done_d   = 1'b1;
                        state_d  = S_FIN;
                    end
                end else begin
                    hc_d = hc_q + 5'd1;
                end
            end
            S_GAP: begin
                // Two half-period counts; k doubles as the phase flag.
                if (hc_last) begin
                    hc_d = 5'd0;
                    if (k_q == 4'd0) begin
                        k_d = 4'd1;
                    end else begin
                        f_d     = 1'b1;
                        state_d = S_SETUP;
                    end
                end else begin
                    hc_d = hc_q + 5'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin outputs are decoded from the next state so they leave flops directly.
    always_comb begin
        cs_n_d  = !(state_d inside {S_SETUP, S_LOW, S_HIGH});
        sclk_d  = (state_d != S_LOW);
        busy_d  = (state_d inside {S_SETUP, S_LOW, S_HIGH, S_GAP});
        saddr_d = saddr_q;
        if (state_d == S_IDLE) begin
            saddr_d = 1'b0;
        end else if ((state_d == S_LOW) && (state_q != S_LOW)) begin
            saddr_d = addr_word[~k_d];
        end
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q  <= S_IDLE;
            hc_q     <= 5'd0;
            k_q      <= 4'd0;
            f_q      <= 1'b0;
            ch_q     <= 3'd0;
            shift_q  <= 16'h0000;
            result_q <= 16'h0000;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            saddr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hc_q     <= hc_d;
            k_q      <= k_d;
            f_q      <= f_d;
            ch_q     <= ch_d;
            shift_q  <= shift_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            saddr_q  <= saddr_d;
        end
    end

    assign result    = result_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign ADC_CS_N  = cs_n_q;
    assign ADC_SCLK  = sclk_q;
    assign ADC_SADDR = saddr_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_adc_sampler                                                             |
// | Scoreboard bench: two controllers (CLK_DIV 25 and 8) with ADC models.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_adc_sampler;

    localparam int DIV0 = 25;
    localparam int DIV1 = 8;

    typedef struct {
        int          inst;
        logic [2:0]  ch;
        logic [15:0] res;
        int          due;
    } exp_t;

    logic        sysclk = 1'b0;
    logic        sysreset = 1'b1;
    logic [15:0] cmd_data = 16'h0000;
    logic [1:0]  cmd_load = 2'b00;
    logic [1:0]  sdat = 2'b00;
    wire  [31:0] results;
    wire  [1:0]  busy, done, cs_n, sclk, saddr;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    exp_t sb[$];
    logic [11:0] tbl [2][8];

    adc_sampler #(.CLK_DIV(DIV0)) u_dut0 (
        .sysclk(sysclk), .sysreset(sysreset), .cmd_data(cmd_data), .cmd_load(cmd_load[0]),
        .result(results[15:0]), .busy(busy[0]), .done(done[0]), .ADC_CS_N(cs_n[0]),
        .ADC_SCLK(sclk[0]), .ADC_SADDR(saddr[0]), .ADC_SDAT(sdat[0])
    );

    adc_sampler #(.CLK_DIV(DIV1)) u_dut1 (
        .sysclk(sysclk), .sysreset(sysreset), .cmd_data(cmd_data), .cmd_load(cmd_load[1]),
        .result(results[31:16]), .busy(busy[1]), .done(done[1]), .ADC_CS_N(cs_n[1]),
        .ADC_SCLK(sclk[1]), .ADC_SADDR(saddr[1]), .ADC_SDAT(sdat[1])
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    function automatic int divof(input int i);
        return (i == 0) ? DIV0 : DIV1;
    endfunction

    function automatic logic [15:0] res_of(input int i);
        return (i == 0) ? results[15:0] : results[31:16];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // ADC128S022 model: DOUT moves on SCLK falls (4 zeros then 12 data bits of the
    // channel addressed in the previous frame); DIN is captured on SCLK rises.
    initial begin : adc_model
        logic [1:0]  m_cs;
        logic [1:0]  m_sk;
        int          m_n [2];
        logic [15:0] m_din [2];
        logic [2:0]  m_addr [2];
        logic [11:0] v;
        m_cs = 2'b11;
        m_sk = 2'b11;
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_din[i] = 16'h0000; m_addr[i] = 3'd0;
        end
        forever begin
            @(negedge sysclk);
            for (int i = 0; i < 2; i++) begin
                if (m_cs[i] === 1'b1 && cs_n[i] === 1'b0) begin
                    m_n[i] = 0; m_din[i] = 16'h0000; sdat[i] = 1'b0;
                end else if (m_cs[i] === 1'b0 && cs_n[i] === 1'b1) begin
                    m_addr[i] = m_din[i][13:11];
                end else if (cs_n[i] === 1'b0) begin
                    if (m_sk[i] === 1'b1 && sclk[i] === 1'b0) begin
                        v = tbl[i][m_addr[i]];
                        sdat[i] = (m_n[i] < 4 || m_n[i] > 15) ? 1'b0 : v[15 - m_n[i]];
                        m_n[i]++;
                    end else if (m_sk[i] === 1'b0 && sclk[i] === 1'b1) begin
                        m_din[i] = {m_din[i][14:0], saddr[i]};
                    end
                end
                m_cs[i] = cs_n[i];
                m_sk[i] = sclk[i];
            end
        end
    end

    // Monitor: pops the scoreboard on every done and checks the conversion waveform.
    initial begin : monitor
        exp_t        e;
        logic [1:0]  mon_rst;
        logic [1:0]  mon_sk;
        int          rise_cnt [2];
        int          last_rise [2];
        int          busy_cnt [2];
        logic        per_ok [2];
        logic [31:0] din_cap [2];
        logic [15:0] w;
        mon_rst = 2'b11;
        mon_sk  = 2'b11;
        for (int i = 0; i < 2; i++) begin
            rise_cnt[i] = 0; last_rise[i] = 0; busy_cnt[i] = 0; per_ok[i] = 1'b1; din_cap[i] = 0;
        end
        forever begin
            @(negedge sysclk);
            for (int i = 0; i < 2; i++) begin
                if (sysreset || mon_rst[i]) begin
                    if (!sysreset) check("no_done_after_reset", {31'd0, done[i]}, 0);
                    rise_cnt[i] = 0; busy_cnt[i] = 0; per_ok[i] = 1'b1; din_cap[i] = 0;
                    sb.delete();
                end else begin
                    if (busy[i] === 1'b1) busy_cnt[i]++;
                    if (mon_sk[i] === 1'b0 && sclk[i] === 1'b1) begin
                        if ((rise_cnt[i] % 16) != 0 && (cyc - last_rise[i]) != 2 * divof(i))
                            per_ok[i] = 1'b0;
                        last_rise[i] = cyc;
                        rise_cnt[i]++;
                        din_cap[i] = {din_cap[i][30:0], saddr[i]};
                    end
                    if (done[i] === 1'b1) begin
                        if (sb.size() == 0 || sb[0].inst != i) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_done: inst %0d result 0x%0h, no conversion pending (cycle %0d)",
                                     i, res_of(i), cyc);
                        end else begin
                            e = sb.pop_front();
                            w = {2'b00, e.ch, 11'b0};
                            check("result", {16'd0, res_of(i)}, {16'd0, e.res});
                            check("done_cycle", cyc, e.due);
                            check("sclk_rises", rise_cnt[i], 32);
                            check("sclk_period", {31'd0, per_ok[i]}, 1);
                            check("saddr_pattern", din_cap[i], {w, w});
                            check("busy_length", busy_cnt[i], 68 * divof(i));
                            check("cs_n_fin", {31'd0, cs_n[i]}, 1);
                        end
                        rise_cnt[i] = 0; busy_cnt[i] = 0; per_ok[i] = 1'b1; din_cap[i] = 0;
                    end
                end
                mon_rst[i] = sysreset;
                mon_sk[i]  = sclk[i];
            end
        end
    end

    task automatic issue(input int i, input logic [2:0] ch, output int l);
        exp_t e;
        tick();
        cmd_data    = {13'($urandom), ch};
        cmd_load[i] = 1'b1;
        l     = cyc;
        e.inst = i;
        e.ch   = ch;
        e.res  = {1'b1, ch, tbl[i][ch]};
        e.due  = l + 68 * divof(i) + 1;
        sb.push_back(e);
        tick();
        cmd_load[i] = 1'b0;
        @(negedge sysclk);
        check("busy_start", {31'd0, busy[i]}, 1);
        check("cs_n_start", {31'd0, cs_n[i]}, 0);
        check("valid_cleared", {31'd0, res_of(i)[15]}, 0);
    endtask

    // Waits for the pending conversion; optionally pulses a stray cmd_load at l+ign.
    task automatic wait_done(input int i, input int l, input int ign);
        int lim;
        lim = 68 * divof(i) + 8;
        for (int t = 0; t < lim; t++) begin
            @(negedge sysclk);
            #1;
            if (ign > 0) begin
                cmd_load[i] = (cyc == l + ign);
                if (cyc == l + ign) cmd_data = {13'($urandom), 3'($urandom)};
            end
            if (sb.size() == 0 && cmd_load[i] == 1'b0) return;
        end
        check("done_timeout", sb.size(), 0);
        sb.delete();
        cmd_load[i] = 1'b0;
    endtask

    task automatic check_idle(input int i);
        @(negedge sysclk);
        check("done_one_cycle", {31'd0, done[i]}, 0);
        check("idle_after", {31'd0, busy[i]}, 0);
    endtask

    initial begin : stim
        int l;
        int sel;
        int ign;
        logic [2:0] ch;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 8; c++) tbl[i][c] = 12'($urandom);
        tbl[0][5] = 12'hABC;
        tbl[0][2] = 12'h123;
        tbl[1][3] = 12'hFFF;

        repeat (3) tick();
        sysreset = 1'b0;
        @(negedge sysclk);
        for (int i = 0; i < 2; i++) begin
            check("rst_cs_n", {31'd0, cs_n[i]}, 1);
            check("rst_sclk", {31'd0, sclk[i]}, 1);
            check("rst_saddr", {31'd0, saddr[i]}, 0);
            check("rst_busy", {31'd0, busy[i]}, 0);
            check("rst_done", {31'd0, done[i]}, 0);
            check("rst_result", {16'd0, res_of(i)}, 0);
        end

        // Channel 5 read, then channel 2 with a stray load at cycle 400.
        issue(0, 3'd5, l);
        wait_done(0, l, 0);
        check_idle(0);
        issue(0, 3'd2, l);
        wait_done(0, l, 400);
        check_idle(0);

        // Reset in frame 1 at bit 7, then a clean channel 0 read.
        issue(0, 3'd6, l);
        for (int t = 0; t < 1300 && cyc != l + 1260; t++) begin
            @(negedge sysclk);
            #1;
        end
        check("sclk_low_k7", {31'd0, sclk[0]}, 0);
        check("busy_k7", {31'd0, busy[0]}, 1);
        sysreset = 1'b1;
        @(negedge sysclk);
        #1;
        check("mid_rst_cs_n", {31'd0, cs_n[0]}, 1);
        check("mid_rst_sclk", {31'd0, sclk[0]}, 1);
        check("mid_rst_busy", {31'd0, busy[0]}, 0);
        check("mid_rst_done", {31'd0, done[0]}, 0);
        check("mid_rst_result", {16'd0, res_of(0)}, 0);
        sysreset = 1'b0;
        repeat (500) @(negedge sysclk);
        issue(0, 3'd0, l);
        wait_done(0, l, 0);
        check_idle(0);

        // Back-to-back: second load lands in the cycle right after FIN.
        issue(0, 3'd4, l);
        wait_done(0, l, 0);
        issue(0, 3'd1, l);
        wait_done(0, l, 0);
        check_idle(0);

        // Fast divider, channel 3.
        issue(1, 3'd3, l);
        wait_done(1, l, 0);
        check_idle(1);

        // Randomised conversions with stray loads while busy or in FIN.
        for (int n = 0; n < 10; n++) begin
            int i;
            i = (n < 6) ? 0 : 1;
            for (int c = 0; c < 8; c++) tbl[i][c] = 12'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            ch  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 2);
            ign = (sel == 0) ? 0 :
                  (sel == 1) ? $urandom_range(2, 68 * divof(i)) : 68 * divof(i) + 1;
            issue(i, ch, l);
            wait_done(i, l, ign);
            check_idle(i);
        end

        repeat (5) @(negedge sysclk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
